// File: rtl/alarm_pkg.sv
// Shared types and helpers for the alarm scheduler.
//   alarm_state_t : scheduler FSM state encoding
//   bcd_time_t    : packed {hourdec, hourone, mindec, minone} BCD time
//   cnt_width()   : width of a counter that must hold 0..max_val (at least 1 bit)
package alarm_pkg;

    localparam int BCD_W = 16;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RINGING = 2'd1,
        SNOOZE  = 2'd2
    } alarm_state_t;

    typedef struct packed {
        logic [3:0] hourdec;
        logic [3:0] hourone;
        logic [3:0] mindec;
        logic [3:0] minone;
    } bcd_time_t;

    function automatic int cnt_width(input int max_val);
        return (max_val < 1) ? 1 : $clog2(max_val + 1);
    endfunction

endpackage

// File: rtl/alarm_slot_match.sv
// Combinational per-slot time comparators.
//   now_time : current BCD time
//   bud_time : slot i alarm time at [16i+15:16i]
//   bud_on   : per-slot enable
//   match    : slot i is enabled and its time equals now_time
module alarm_slot_match
    import alarm_pkg::*;
#(
    parameter int N_SLOTS = 2
) (
    input  logic [BCD_W-1:0]         now_time,
    input  logic [BCD_W*N_SLOTS-1:0] bud_time,
    input  logic [N_SLOTS-1:0]       bud_on,
    output logic [N_SLOTS-1:0]       match
);

    // NOTE: every output of a combinational block gets a default first, so no
    // path through the block leaves it unassigned and a latch is never inferred.
    always_comb begin
        match = '0;
        for (int i = 0; i < N_SLOTS; i++) begin
            match[i] = bud_on[i] && (bud_time[BCD_W*i +: BCD_W] == now_time);
        end
    end

endmodule

// File: rtl/alarm_scheduler.sv
// Multi-slot alarm scheduler sharing one buzzer enable between N_SLOTS alarms.
// Each minute change queues every enabled matching slot; queued slots are then
// served one at a time, lowest index first, with beep, ring timeout and snooze.
//   clk, rst    : clock, synchronous active-high reset
//   sec_tick    : one-cycle 1 Hz strobe
//   now_time    : running BCD time
//   bud_time    : per-slot alarm times, bud_on : per-slot enables
//   off_bud     : dismiss pulse, snooze_bud : snooze pulse
//   aud_en      : registered buzzer enable
//   active_slot : slot being served (valid while busy)
//   busy        : ringing or snoozing
//   pending     : queued triggers not yet served
module alarm_scheduler
    import alarm_pkg::*;
#(
    parameter  int N_SLOTS     = 2,
    parameter  int RING_SECS   = 60,
    parameter  int SNOOZE_SECS = 300,
    parameter  int MAX_SNOOZE  = 3,
    localparam int SLOT_W      = (N_SLOTS > 1) ? $clog2(N_SLOTS) : 1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     sec_tick,
    input  logic [BCD_W-1:0]         now_time,
    input  logic [BCD_W*N_SLOTS-1:0] bud_time,
    input  logic [N_SLOTS-1:0]       bud_on,
    input  logic                     off_bud,
    input  logic                     snooze_bud,
    output logic                     aud_en,
    output logic [SLOT_W-1:0]        active_slot,
    output logic                     busy,
    output logic [N_SLOTS-1:0]       pending
);

    localparam int RING_W = cnt_width(RING_SECS);
    localparam int SNZ_W  = cnt_width(SNOOZE_SECS);
    localparam int SCNT_W = cnt_width(MAX_SNOOZE);

    localparam logic [RING_W-1:0] RING_MAX = RING_W'(RING_SECS);
    localparam logic [SNZ_W-1:0]  SNZ_MAX  = SNZ_W'(SNOOZE_SECS);
    localparam logic [SCNT_W-1:0] SCNT_MAX = SCNT_W'(MAX_SNOOZE);

    alarm_state_t       state;
    bcd_time_t          now_q;
    logic               time_vld;
    logic               phase;
    logic [RING_W-1:0]  ring_cnt;
    logic [SNZ_W-1:0]   snz_cnt;
    logic [SCNT_W-1:0]  snooze_cnt;

    logic [N_SLOTS-1:0] match;
    logic [N_SLOTS-1:0] pending_next;
    logic [SLOT_W-1:0]  pick;
    logic               take;
    logic               minute_evt;
    logic               active_on;
    logic [RING_W-1:0]  ring_nxt;
    logic [SNZ_W-1:0]   snz_nxt;

    alarm_slot_match #(
        .N_SLOTS (N_SLOTS)
    ) u_match (
        .now_time (now_time),
        .bud_time (bud_time),
        .bud_on   (bud_on),
        .match    (match)
    );

    // time_vld masks the first load after reset so the current minute never fires.
    assign minute_evt = time_vld && (bcd_time_t'(now_time) != now_q);
    assign take       = (state == IDLE) && (|pending);
    assign active_on  = bud_on[active_slot];

    // Counters saturate at their terminal value instead of wrapping.
    assign ring_nxt = (ring_cnt == RING_MAX) ? ring_cnt : ring_cnt + 1'b1;
    assign snz_nxt  = (snz_cnt  == SNZ_MAX)  ? snz_cnt  : snz_cnt  + 1'b1;

    // Lowest set index wins: scan downward so the last hit is the smallest.
    always_comb begin
        pick = '0;
        for (int i = N_SLOTS - 1; i >= 0; i--) begin
            if (pending[i]) pick = SLOT_W'(i);
        end
    end

    // The served bit is cleared before new matches are merged, so a minute event
    // on the take cycle re-queues that slot as a fresh trigger.
    always_comb begin
        pending_next = pending;
        if (take) pending_next[pick] = 1'b0;
        if (minute_evt) pending_next = pending_next | match;
        pending_next = pending_next & bud_on;
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order in this block.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            now_q       <= '0;
            time_vld    <= 1'b0;
            pending     <= '0;
            aud_en      <= 1'b0;
            busy        <= 1'b0;
            active_slot <= '0;
            phase       <= 1'b0;
            ring_cnt    <= '0;
            snz_cnt     <= '0;
            snooze_cnt  <= '0;
        end else begin
            now_q    <= bcd_time_t'(now_time);
            time_vld <= 1'b1;
            pending  <= pending_next;

            case (state)
                IDLE: begin
                    if (take) begin
                        state       <= RINGING;
                        active_slot <= pick;
                        snooze_cnt  <= '0;
                        ring_cnt    <= '0;
                        phase       <= 1'b1;
                        aud_en      <= 1'b1;
                        busy        <= 1'b1;
                    end
                end

                RINGING: begin
                    // Buttons outrank the tick/timeout seen on the same cycle.
                    if (!active_on || off_bud ||
                        (snooze_bud && snooze_cnt == SCNT_MAX)) begin
                        state  <= IDLE;
                        aud_en <= 1'b0;
                        busy   <= 1'b0;
                    end else if (snooze_bud) begin
                        state      <= SNOOZE;
                        snooze_cnt <= snooze_cnt + 1'b1;
                        snz_cnt    <= '0;
                        aud_en     <= 1'b0;
                    end else if (sec_tick) begin
                        ring_cnt <= ring_nxt;
                        phase    <= ~phase;
                        if (ring_nxt == RING_MAX) begin
                            state  <= IDLE;
                            aud_en <= 1'b0;
                            busy   <= 1'b0;
                        end else begin
                            aud_en <= ~phase;
                        end
                    end
                end

                SNOOZE: begin
                    if (!active_on || off_bud) begin
                        state  <= IDLE;
                        aud_en <= 1'b0;
                        busy   <= 1'b0;
                    end else if (sec_tick) begin
                        snz_cnt <= snz_nxt;
                        if (snz_nxt == SNZ_MAX) begin
                            state    <= RINGING;
                            ring_cnt <= '0;
                            phase    <= 1'b1;
                            aud_en   <= 1'b1;
                        end
                    end
                end

                default: begin
                    state  <= IDLE;
                    aud_en <= 1'b0;
                    busy   <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alarm_scheduler.sv
// Self-checking bench for alarm_scheduler (N_SLOTS=2, RING_SECS=4,
// SNOOZE_SECS=3, MAX_SNOOZE=2). Table rows drive one cycle each; the expected
// outputs are queued when driven and popped when sampled after the edge.
module tb_alarm_scheduler;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        sec_tick = 1'b0;
    logic [15:0] now_time = 16'h0000;
    logic [31:0] bud_time = 32'h0;
    logic [1:0]  bud_on = 2'b00;
    logic        off_bud = 1'b0;
    logic        snooze_bud = 1'b0;
    logic        aud_en;
    logic [0:0]  active_slot;
    logic        busy;
    logic [1:0]  pending;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        string       name;
        logic        r, tk, of, sz;
        logic [15:0] nw;
        logic [31:0] bt;
        logic [1:0]  on;
        logic        ea, eb;
        logic [1:0]  ep;
        logic        es;
    } vec_t;

    vec_t vecs[$];
    vec_t exp_q[$];

    alarm_scheduler #(
        .N_SLOTS     (2),
        .RING_SECS   (4),
        .SNOOZE_SECS (3),
        .MAX_SNOOZE  (2)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .sec_tick    (sec_tick),
        .now_time    (now_time),
        .bud_time    (bud_time),
        .bud_on      (bud_on),
        .off_bud     (off_bud),
        .snooze_bud  (snooze_bud),
        .aud_en      (aud_en),
        .active_slot (active_slot),
        .busy        (busy),
        .pending     (pending)
    );

    always #5 clk = ~clk;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic add(input string nm, input logic r, tk, of, sz,
                       input logic [15:0] nw, input logic [31:0] bt, input logic [1:0] on,
                       input logic ea, eb, input logic [1:0] ep, input logic es);
        vec_t v;
        v.name = nm; v.r = r; v.tk = tk; v.of = of; v.sz = sz;
        v.nw = nw; v.bt = bt; v.on = on;
        v.ea = ea; v.eb = eb; v.ep = ep; v.es = es;
        vecs.push_back(v);
    endtask

    // One cycle with the current time/slot settings and the given pulses.
    task automatic cyc(input logic tk, of, sz);
        @(negedge clk);
        sec_tick = tk; off_bud = of; snooze_bud = sz;
        @(posedge clk);
        #1;
    endtask

    initial begin
        vec_t e;
        logic [31:0] act, exp;
        int ticks;

        // ---- basic ring: slot0=07:30 ----------------------------------------
        add("rst_hold",   1,0,0,0, 16'h0729, 32'h0000_0730, 2'b01, 0,0,2'b00,0);
        add("post_rst",   0,0,0,0, 16'h0729, 32'h0000_0730, 2'b01, 0,0,2'b00,0);
        add("steady",     0,0,0,0, 16'h0729, 32'h0000_0730, 2'b01, 0,0,2'b00,0);
        add("min_evt",    0,0,0,0, 16'h0730, 32'h0000_0730, 2'b01, 0,0,2'b01,0);
        add("ring_in",    0,0,0,0, 16'h0730, 32'h0000_0730, 2'b01, 1,1,2'b00,0);
        add("tick1",      0,1,0,0, 16'h0730, 32'h0000_0730, 2'b01, 0,1,2'b00,0);
        add("no_tick",    0,0,0,0, 16'h0730, 32'h0000_0730, 2'b01, 0,1,2'b00,0);
        add("tick2",      0,1,0,0, 16'h0730, 32'h0000_0730, 2'b01, 1,1,2'b00,0);
        add("tick3",      0,1,0,0, 16'h0730, 32'h0000_0730, 2'b01, 0,1,2'b00,0);
        add("tick4_tmo",  0,1,0,0, 16'h0730, 32'h0000_0730, 2'b01, 0,0,2'b00,0);
        add("idle_after", 0,0,0,0, 16'h0730, 32'h0000_0730, 2'b01, 0,0,2'b00,0);
        // ---- off beats snooze -----------------------------------------------
        add("b_evt",      0,0,0,0, 16'h0731, 32'h0000_0731, 2'b01, 0,0,2'b01,0);
        add("b_ring",     0,0,0,0, 16'h0731, 32'h0000_0731, 2'b01, 1,1,2'b00,0);
        add("off_snz",    0,0,1,1, 16'h0731, 32'h0000_0731, 2'b01, 0,0,2'b00,0);
        add("off_stay",   0,0,0,0, 16'h0731, 32'h0000_0731, 2'b01, 0,0,2'b00,0);
        // ---- snooze limit ---------------------------------------------------
        add("c_evt",      0,0,0,0, 16'h0732, 32'h0000_0732, 2'b01, 0,0,2'b01,0);
        add("c_ring",     0,0,0,0, 16'h0732, 32'h0000_0732, 2'b01, 1,1,2'b00,0);
        add("snz1",       0,0,0,1, 16'h0732, 32'h0000_0732, 2'b01, 0,1,2'b00,0);
        add("snz_ignore", 0,0,0,1, 16'h0732, 32'h0000_0732, 2'b01, 0,1,2'b00,0);
        add("s1_t1",      0,1,0,0, 16'h0732, 32'h0000_0732, 2'b01, 0,1,2'b00,0);
        add("s1_t2",      0,1,0,0, 16'h0732, 32'h0000_0732, 2'b01, 0,1,2'b00,0);
        add("s1_rering",  0,1,0,0, 16'h0732, 32'h0000_0732, 2'b01, 1,1,2'b00,0);
        add("snz2",       0,0,0,1, 16'h0732, 32'h0000_0732, 2'b01, 0,1,2'b00,0);
        add("s2_t1",      0,1,0,0, 16'h0732, 32'h0000_0732, 2'b01, 0,1,2'b00,0);
        add("s2_t2",      0,1,0,0, 16'h0732, 32'h0000_0732, 2'b01, 0,1,2'b00,0);
        add("s2_rering",  0,1,0,0, 16'h0732, 32'h0000_0732, 2'b01, 1,1,2'b00,0);
        add("s2_beep",    0,1,0,0, 16'h0732, 32'h0000_0732, 2'b01, 0,1,2'b00,0);
        add("snz3_off",   0,0,0,1, 16'h0732, 32'h0000_0732, 2'b01, 0,0,2'b00,0);
        // ---- queueing: both slots 06:00 -------------------------------------
        add("q_evt",      0,0,0,0, 16'h0600, 32'h0600_0600, 2'b11, 0,0,2'b11,0);
        add("q_slot0",    0,0,0,0, 16'h0600, 32'h0600_0600, 2'b11, 1,1,2'b10,0);
        add("q_hold",     0,0,0,0, 16'h0600, 32'h0600_0600, 2'b11, 1,1,2'b10,0);
        add("q_off0",     0,0,1,0, 16'h0600, 32'h0600_0600, 2'b11, 0,0,2'b10,0);
        add("q_slot1",    0,0,0,0, 16'h0600, 32'h0600_0600, 2'b11, 1,1,2'b00,1);
        add("q_off1",     0,0,1,0, 16'h0600, 32'h0600_0600, 2'b11, 0,0,2'b00,0);
        // ---- disable during snooze ------------------------------------------
        add("e_evt",      0,0,0,0, 16'h0601, 32'h0600_0601, 2'b11, 0,0,2'b01,0);
        add("e_ring",     0,0,0,0, 16'h0601, 32'h0600_0601, 2'b11, 1,1,2'b00,0);
        add("e_snz",      0,0,0,1, 16'h0601, 32'h0600_0601, 2'b11, 0,1,2'b00,0);
        add("e_disable",  0,0,0,0, 16'h0601, 32'h0600_0601, 2'b10, 0,0,2'b00,0);
        // ---- reset mid-ring and 23:59 boundary ------------------------------
        add("f_evt",      0,0,0,0, 16'h0602, 32'h0600_0602, 2'b01, 0,0,2'b01,0);
        add("f_ring",     0,0,0,0, 16'h0602, 32'h0600_0602, 2'b01, 1,1,2'b00,0);
        add("f_rst",      1,0,0,0, 16'h0600, 32'h0600_0600, 2'b01, 0,0,2'b00,0);
        add("f_rel",      0,0,0,0, 16'h0600, 32'h0600_0600, 2'b01, 0,0,2'b00,0);
        add("f_notrig",   0,0,0,0, 16'h0600, 32'h0600_0600, 2'b01, 0,0,2'b00,0);
        add("f_notrig2",  0,0,0,0, 16'h0600, 32'h0600_0600, 2'b01, 0,0,2'b00,0);
        add("f_2358",     0,0,0,0, 16'h2358, 32'h0600_2359, 2'b01, 0,0,2'b00,0);
        add("f_2359",     0,0,0,0, 16'h2359, 32'h0600_2359, 2'b01, 0,0,2'b01,0);
        add("f_ring2359", 0,0,0,0, 16'h2359, 32'h0600_2359, 2'b01, 1,1,2'b00,0);
        add("f_off",      0,0,1,0, 16'h2359, 32'h0600_2359, 2'b01, 0,0,2'b00,0);
        add("f_0000",     0,0,0,0, 16'h0000, 32'h0600_2359, 2'b01, 0,0,2'b00,0);
        add("f_quiet",    0,0,0,0, 16'h0000, 32'h0600_2359, 2'b01, 0,0,2'b00,0);

        foreach (vecs[i]) begin
            @(negedge clk);
            rst = vecs[i].r; sec_tick = vecs[i].tk; off_bud = vecs[i].of;
            snooze_bud = vecs[i].sz; now_time = vecs[i].nw;
            bud_time = vecs[i].bt; bud_on = vecs[i].on;
            exp_q.push_back(vecs[i]);
            @(posedge clk);
            #1;
            e   = exp_q.pop_front();
            act = {27'b0, aud_en, busy, pending, (e.eb ? active_slot[0] : 1'b0)};
            exp = {27'b0, e.ea, e.eb, e.ep, e.es};
            check(e.name, act, exp);
        end

        // ---- hand sequence: ring length in ticks, bounded -------------------
        @(negedge clk);
        bud_on = 2'b01; bud_time = 32'h0600_0001; now_time = 16'h0001;
        cyc(0, 0, 0);
        cyc(0, 0, 0);
        check("h_ring_start", {30'b0, aud_en, busy}, 32'h3);
        ticks = 0;
        for (int k = 0; k < 20 && busy; k++) begin
            cyc(1, 0, 0);
            ticks++;
            cyc(0, 0, 0);
        end
        check("h_ring_len", ticks, 4);
        check("h_ring_done", {31'b0, busy}, 32'h0);

        // ---- hand sequence: trigger while busy, off beats tick --------------
        @(negedge clk);
        bud_on = 2'b11; bud_time = 32'h0004_0002; now_time = 16'h0002;
        cyc(0, 0, 0);
        cyc(0, 0, 0);
        cyc(0, 0, 1);
        check("h_snooze", {30'b0, aud_en, busy}, 32'h1);
        @(negedge clk);
        now_time = 16'h0004;
        cyc(0, 0, 0);
        check("h_pend_busy", {30'b0, pending}, 32'h2);
        cyc(1, 1, 0);
        check("h_off_tick", {29'b0, aud_en, busy, pending[1]}, 32'h1);
        cyc(0, 0, 0);
        check("h_serve1", {29'b0, aud_en, busy, active_slot}, 32'h7);
        check("h_pend_clr", {30'b0, pending}, 32'h0);
        cyc(0, 1, 0);
        check("h_final_idle", {31'b0, busy}, 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
